// File: rtl/clause_feedback_generator.sv
// Issues per-clause Type I / Type II feedback for one training sample over a valid/ready stream.
// Build option: define FB_SKIP_NONE_EN to suppress beats for unselected clauses.
module clause_feedback_generator #(
  parameter int          N_CL      = 10,
  parameter int          T         = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            target,
  input  logic [N_CL-1:0] pos_clause,
  input  logic [N_CL-1:0] neg_clause,
  output logic            busy,
  output logic            fb_valid,
  input  logic            fb_ready,
  output logic [4:0]      fb_idx,
  output logic [1:0]      fb_type,
  output logic            done
);

  localparam int                 CW      = $clog2(N_CL + 1);
  localparam logic [15:0]        SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic signed [7:0]  T_S     = 8'(T);
  localparam logic [6:0]         T2      = 7'(2 * T);
  localparam logic [4:0]         N_CL_5  = 5'(N_CL);
  localparam logic [4:0]         LAST_K  = 5'(2 * N_CL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUM,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              tgt_q;
  logic [N_CL-1:0]   pos_q, neg_q;
  logic [6:0]        num_q;
  logic [4:0]        k_q;
  logic [15:0]       lfsr_q;

  logic              accept;
  logic              step;
  logic              sel;
  logic              last_slot;
  logic [1:0]        cls;
  logic [14:0]       scaled;
  logic [15:0]       lfsr_next;
  logic [CW-1:0]     pos_cnt, neg_cnt;
  logic signed [7:0] vote, vote_clip;
  logic [6:0]        num_d;

  function automatic logic [CW-1:0] popcount(input logic [N_CL-1:0] bits);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_CL; i++) cnt = cnt + CW'(bits[i]);
    return cnt;
  endfunction

  // Class sum, clipped to +/-T, turned into the selection numerator 0..2T.
  always_comb begin
    pos_cnt = popcount(pos_q);
    neg_cnt = popcount(neg_q);
    vote    = 8'(pos_cnt) - 8'(neg_cnt);
    if (vote > T_S)       vote_clip = T_S;
    else if (vote < -T_S) vote_clip = -T_S;
    else                  vote_clip = vote;
    num_d = tgt_q ? 7'(T_S - vote_clip) : 7'(T_S + vote_clip);
  end

  // Maps the low LFSR byte onto 0..2T-1, so num=0 never selects and num=2T always does.
  assign scaled    = 15'(lfsr_q[7:0]) * 15'(T2);
  assign sel       = 7'(scaled >> 8) < num_q;
  assign cls       = ((k_q < N_CL_5) == tgt_q) ? 2'b01 : 2'b10;
  assign last_slot = (k_q == LAST_K);
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign accept    = (state_q == S_IDLE) && start;
  assign fb_idx    = k_q;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    fb_valid = 1'b0;
    fb_type  = 2'b00;
    step     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SUM;
      end
      S_SUM: begin
        busy    = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        busy = 1'b1;
`ifdef FB_SKIP_NONE_EN
        fb_valid = sel;
        step     = !sel || fb_ready;
`else
        fb_valid = 1'b1;
        step     = fb_ready;
`endif
        fb_type = sel ? cls : 2'b00;
        if (step && last_slot) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      k_q     <= '0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      if (accept)             k_q   <= '0;
      if (state_q == S_SUM)   num_q <= num_d;
      if (step) begin
        lfsr_q <= lfsr_next;
        k_q    <= last_slot ? 5'd0 : k_q + 5'd1;
      end
    end
  end

  // NOTE: the sample capture registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      tgt_q <= target;
      pos_q <= pos_clause;
      neg_q <= neg_clause;
    end
  end

endmodule

// File: tb/tb_clause_feedback_generator.sv
// Randomized bench for clause_feedback_generator against a sample-level feedback model.
// Honours FB_SKIP_NONE_EN the same way the design does.
module tb_clause_feedback_generator;

  localparam int N_CL = 10;
  localparam int T    = 4;
  localparam int NS   = 2 * N_CL;
`ifdef FB_SKIP_NONE_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            target;
  logic [N_CL-1:0] pos_clause;
  logic [N_CL-1:0] neg_clause;
  logic            busy;
  logic            fb_valid;
  logic            fb_ready;
  logic [4:0]      fb_idx;
  logic [1:0]      fb_type;
  logic            done;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int idx;
    int typ;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] m_lfsr;

  clause_feedback_generator #(.N_CL(N_CL), .T(T), .LFSR_SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .target     (target),
    .pos_clause (pos_clause),
    .neg_clause (neg_clause),
    .busy       (busy),
    .fb_valid   (fb_valid),
    .fb_ready   (fb_ready),
    .fb_idx     (fb_idx),
    .fb_type    (fb_type),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Expected beat list for one sample, from the vote/threshold rules.
  task automatic build_expected(input logic tgt, input logic [N_CL-1:0] p, input logic [N_CL-1:0] n);
    int v;
    int vc;
    int num;
    exp_q.delete();
    v  = $countones(p) - $countones(n);
    vc = (v > T) ? T : ((v < -T) ? -T : v);
    num = tgt ? (T - vc) : (T + vc);
    for (int k = 0; k < NS; k++) begin
      int    r;
      bit    sel;
      int    cls;
      beat_t b;
      r   = int'(m_lfsr[7:0]);
      sel = ((r * 2 * T) / 256) < num;
      cls = ((k < N_CL) == tgt) ? 1 : 2;
      b.idx = k;
      b.typ = sel ? cls : 0;
      if (!SKIP || sel) exp_q.push_back(b);
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  // mode: 0 = fb_ready high, 1 = toggling, 2 = random.
  task automatic run_sample(input string name, input logic tgt, input logic [N_CL-1:0] p,
                            input logic [N_CL-1:0] n, input int mode, input bit poke_start);
    int          c;
    int          done_cycle;
    int          first_valid;
    bit          got_done;
    bit          stalled;
    logic [4:0]  prev_idx;
    logic [1:0]  prev_type;
    beat_t       e;
    build_expected(tgt, p, n);
    @(negedge clk);
    target = tgt; pos_clause = p; neg_clause = n; start = 1'b1; fb_ready = 1'b0;
    c = 0; got_done = 1'b0; stalled = 1'b0; done_cycle = -1; first_valid = -1;
    prev_idx = '0; prev_type = '0;
    while (!got_done && c < 400) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        target = ~tgt; pos_clause = ~p; neg_clause = ~n;
      end
      start = (poke_start && c == 5);
      case (mode)
        0:       fb_ready = 1'b1;
        1:       fb_ready = (c % 2) == 1;
        default: fb_ready = 1'($urandom_range(0, 1));
      endcase
      if (!done) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s busy c=%0d: got %b expected 1", name, c, busy);
        end
      end
      if (stalled) begin
        vectors++;
        if (fb_valid !== 1'b1 || fb_idx !== prev_idx || fb_type !== prev_type) begin
          miscompares++;
          $display("FAIL %s stall_hold c=%0d: got v=%b idx=%0d type=%0d expected v=1 idx=%0d type=%0d",
                   name, c, fb_valid, fb_idx, fb_type, prev_idx, prev_type);
        end
      end
      if (fb_valid === 1'b1) begin
        if (first_valid < 0) first_valid = c;
        vectors++;
        if (fb_type === 2'b11 || (SKIP && fb_type === 2'b00)) begin
          miscompares++;
          $display("FAIL %s illegal_type c=%0d: got %0d", name, c, fb_type);
        end
        if (fb_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s extra_beat: got idx=%0d type=%0d expected no beat", name, fb_idx, fb_type);
          end else begin
            e = exp_q.pop_front();
            if (int'(fb_idx) !== e.idx || int'(fb_type) !== e.typ) begin
              miscompares++;
              $display("FAIL %s beat: got idx=%0d type=%0d expected idx=%0d type=%0d",
                       name, fb_idx, fb_type, e.idx, e.typ);
            end
          end
        end
      end
      stalled   = (fb_valid === 1'b1) && !fb_ready;
      prev_idx  = fb_idx;
      prev_type = fb_type;
      if (done === 1'b1) begin
        got_done   = 1'b1;
        done_cycle = c;
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
        end
      end
    end
    vectors++;
    if (!got_done) begin
      miscompares++;
      $display("FAIL %s timeout: no done within %0d cycles", name, c);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing_beats: got %0d left expected 0", name, exp_q.size());
    end
    if (mode == 0 && got_done) begin
      vectors++;
      if (done_cycle != 2 + NS) begin
        miscompares++;
        $display("FAIL %s done_latency: got %0d expected %0d", name, done_cycle, 2 + NS);
      end
      if (!SKIP) begin
        vectors++;
        if (first_valid != 2) begin
          miscompares++;
          $display("FAIL %s first_valid_latency: got %0d expected 2", name, first_valid);
        end
      end
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || fb_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s idle_after_done: got done=%b busy=%b valid=%b expected 0 0 0",
                 name, done, busy, fb_valid);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (busy !== 1'b0 || fb_valid !== 1'b0 || fb_idx !== 5'd0 || fb_type !== 2'b00 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got busy=%b valid=%b idx=%0d type=%0d done=%b expected all 0",
               name, busy, fb_valid, fb_idx, fb_type, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; target = 1'b0; fb_ready = 1'b0;
    pos_clause = '0; neg_clause = '0;
    m_lfsr = 16'hACE1;
    #1 check_reset_outputs("reset_initial");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_saturated_correct();
    run_sample("sat_correct", 1'b1, 10'h3FF, 10'h000, 0, 1'b0);
  endtask

  task automatic test_saturated_wrong();
    run_sample("sat_wrong", 1'b1, 10'h000, 10'h3FF, 0, 1'b0);
  endtask

  task automatic test_target_zero();
    run_sample("target_zero", 1'b0, 10'h3FF, 10'h000, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [N_CL-1:0] p;
    logic [N_CL-1:0] n;
    logic            t;
    for (int i = 0; i < 4; i++) begin
      p = N_CL'($urandom); n = N_CL'($urandom); t = 1'($urandom);
      run_sample("bp_toggle", t, p, n, 1, 1'b0);
      run_sample("bp_random", t, p, n, 2, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [N_CL-1:0] p;
    logic [N_CL-1:0] n;
    for (int i = 0; i < 20; i++) begin
      p = N_CL'($urandom) & N_CL'($urandom_range(0, 1) ? $urandom : 32'h3FF);
      n = N_CL'($urandom) & N_CL'($urandom_range(0, 1) ? $urandom : 32'h3FF);
      run_sample("random", 1'($urandom), p, n, $urandom_range(0, 2), 1'($urandom));
    end
  endtask

  task automatic test_start_while_busy();
    run_sample("start_busy_num0", 1'b1, 10'h3FF, 10'h000, 0, 1'b1);
    run_sample("start_busy_rand", 1'($urandom), N_CL'($urandom), N_CL'($urandom), 0, 1'b1);
  endtask

  task automatic test_reset_mid_issue();
    @(negedge clk);
    target = 1'b1; pos_clause = 10'h000; neg_clause = 10'h3FF; start = 1'b1; fb_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if (fb_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_precondition: got valid=%b busy=%b expected 1 1", fb_valid, busy);
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_mid_async");
    @(negedge clk);
    check_reset_outputs("reset_mid_held");
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_mid_no_beats");
    run_sample("after_reset", 1'($urandom), N_CL'($urandom), N_CL'($urandom), 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_saturated_correct();
    test_saturated_wrong();
    test_target_zero();
    test_backpressure();
    test_start_while_busy();
    test_random();
    test_reset_mid_issue();
    test_saturated_wrong();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
